// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction fetch stage.
// Holds the fetch FSM state enum, reset vector default and opcode field bounds.

package if_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP,
        S_HOLD
    } if_state_e;

    // R3000 reset vector.
    localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;

    // One IF/ID entry: instruction word plus the address it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// if_skid_buf: single-entry skid buffer for the IF/ID boundary.
// Ports: clk, rst, push/pop/clear controls, push_data in, data/full out.

module if_skid_buf
    import if_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  logic   clear,
    input  if_id_t push_data,
    output if_id_t data,
    output logic   full
);

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            data <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (push) begin
            full <= 1'b1;
            data <= push_data;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch with one outstanding request and IF/ID register.
// Ports: clk, rst, stall, redirect/redirect_pc, imem_* request/response,
// if_valid/if_instr/if_pc/if_opcode to decode. Optional perf counters
// perf_fetch_cnt/perf_stall_cnt exist when IF_PERF_CNT_EN is defined.

module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [5:0]  if_opcode
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    if_state_e   state;
    logic [31:0] pc;
    logic [31:0] req_addr;
    logic [31:0] tgt;
    logic        accept;

    logic        skid_push;
    logic        skid_pop;
    logic        skid_full;
    if_id_t      skid_data;

    logic        load_wait;
    logic        load;
    logic        drain;
    if_id_t      ifid_next;

    assign tgt       = word_align(redirect_pc);
    assign accept    = imem_req & imem_ready;
    assign imem_addr = pc;
    assign if_opcode = if_instr[OPCODE_MSB:OPCODE_LSB];

    // Response lands directly in IF/ID when the old entry is
    // empty or being consumed; otherwise it parks in the skid.
    assign load_wait = (state == S_WAIT) & imem_rvalid
                     & ~redirect & (~if_valid | ~stall);
    assign skid_push = (state == S_WAIT) & imem_rvalid
                     & ~redirect & if_valid & stall;
    assign skid_pop  = (state == S_HOLD) & skid_full
                     & ~stall & ~redirect;

    assign load  = load_wait | skid_pop;
    assign drain = ~redirect & ~load & ~stall;

    assign ifid_next = skid_pop
                     ? skid_data
                     : '{pc: req_addr, instr: imem_rdata};

    if_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (skid_push),
        .pop       (skid_pop),
        .clear     (redirect),
        .push_data ('{pc: req_addr, instr: imem_rdata}),
        .data      (skid_data),
        .full      (skid_full)
    );

    // Fetch FSM; imem_req is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            imem_req <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (redirect) pc <= tgt;
                    state    <= S_REQ;
                    imem_req <= 1'b1;
                end
                S_REQ: begin
                    if (redirect) begin
                        // Accepted-then-redirected response
                        // must still be drained.
                        pc       <= tgt;
                        state    <= accept ? S_DROP : S_REQ;
                        imem_req <= ~accept;
                    end else if (accept) begin
                        req_addr <= pc;
                        pc       <= pc + 32'd4;
                        state    <= S_WAIT;
                        imem_req <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        pc <= tgt;
                        if (imem_rvalid) begin
                            state    <= S_REQ;
                            imem_req <= 1'b1;
                        end else begin
                            state <= S_DROP;
                        end
                    end else if (imem_rvalid) begin
                        if (skid_push) begin
                            state <= S_HOLD;
                        end else begin
                            state    <= S_REQ;
                            imem_req <= 1'b1;
                        end
                    end
                end
                S_DROP: begin
                    if (redirect) pc <= tgt;
                    if (imem_rvalid) begin
                        state    <= S_REQ;
                        imem_req <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        pc       <= tgt;
                        state    <= S_REQ;
                        imem_req <= 1'b1;
                    end else if (!stall) begin
                        state    <= S_REQ;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    // IF/ID register.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
        end else begin
            unique case (1'b1)
                redirect: if_valid <= 1'b0;
                load: begin
                    if_valid <= 1'b1;
                    if_instr <= ifid_next.instr;
                    if_pc    <= ifid_next.pc;
                end
                drain:   if_valid <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (load)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall && if_valid)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, 32'hBFC0_0000, fetch address loaded on reset (R3000 reset vector).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  decode stage cannot accept; hold IF/ID contents.
REQ-005 redirect  input  1  branch/jump taken; restart fetch at redirect_pc.
REQ-006 redirect_pc  input  32  target address; bits [1:0] ignored (forced 0).
REQ-007 imem_req  output  1  fetch request valid.
REQ-008 imem_addr  output  32  word-aligned fetch address.
REQ-009 imem_ready  input  1  memory accepts request this cycle (imem_req & imem_ready = accept).
REQ-010 imem_rvalid  input  1  response data valid; arrives >=1 cycle after accept.
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 if_valid  output  1  IF/ID register holds a valid instruction.
REQ-013 if_instr  output  32  IF/ID instruction.
REQ-014 if_pc  output  32  address of if_instr.
REQ-015 if_opcode  output  6  if_instr[31:26], feeds decoder opcode input.

Function
REQ-016 FSM states SHALL be S_IDLE, S_REQ, S_WAIT, S_DROP, S_HOLD.
REQ-017 S_IDLE -> S_REQ unconditionally the cycle after reset deasserts.
REQ-018 S_REQ: imem_req=1, imem_addr=pc; accept -> S_WAIT, pc <= pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0).
REQ-019 At most one request outstanding; imem_req=0 in S_WAIT, S_DROP, S_HOLD, S_IDLE.
REQ-020 S_WAIT, rvalid, and (!if_valid or !stall): load IF/ID with rdata/request address, if_valid=1, -> S_REQ.
REQ-021 S_WAIT, rvalid, if_valid & stall: capture rdata/address into 1-entry skid buffer -> S_HOLD.
REQ-022 S_HOLD: when stall=0, skid contents move to IF/ID next edge, buffer empties -> S_REQ.
REQ-023 IF/ID with stall=1 and no redirect SHALL hold if_instr/if_pc/if_valid unchanged.
REQ-024 IF/ID with stall=0, valid consumed, and no new data: if_valid <= 0.
REQ-025 redirect (priority over stall and rvalid): pc <= {redirect_pc[31:2],2'b00}, if_valid <= 0, skid buffer cleared, same-cycle rvalid data discarded.
REQ-026 redirect in S_REQ without accept: next cycle S_REQ at new pc; imem_addr changes only on redirect while unaccepted.
REQ-027 redirect in S_WAIT without rvalid, or in S_REQ with same-cycle accept: -> S_DROP; the next rvalid is discarded, then -> S_REQ at new pc.
REQ-028 redirect in S_HOLD or S_WAIT with rvalid: -> S_REQ at new pc.
REQ-029 Redirect-to-first-request latency: 1 cycle (imem_req at new address the cycle after redirect, except S_DROP case).
REQ-030 if_opcode SHALL be purely combinational from if_instr.

Reset
REQ-031 On rst: state=S_IDLE, pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, skid empty, imem_req=0, imem_addr=RESET_PC.
REQ-032 rst mid-transaction abandons the outstanding request; any rvalid in the first S_REQ/S_IDLE cycle after reset is ignored.

Configuration
REQ-033 Macro IF_PERF_CNT_EN: when defined, outputs perf_fetch_cnt[31:0] (increments per instruction loaded into IF/ID) and perf_stall_cnt[31:0] (increments each cycle stall & if_valid), both wrapping, cleared by rst.
REQ-034 Without IF_PERF_CNT_EN the counters and their ports SHALL not exist; all other behaviour identical.

Structure
REQ-035 Package if_pkg SHALL hold the FSM state enum, default RESET_PC constant, and OPCODE_MSB/LSB constants (31/26).
REQ-036 Skid buffer SHALL be sub-module if_skid_buf (1 entry, 64-bit data+addr, push/pop/clear, full flag).

Verification
REQ-037 Reset, imem_ready=1, rvalid 1 cycle later -> imem_addr sequence BFC0_0000, BFC0_0004, BFC0_0008; if_pc follows with if_valid=1.
REQ-038 stall held 3 cycles while response returns -> S_HOLD, single capture into skid, no new imem_req; after release if_instr sequence has no loss or duplicate.
REQ-039 redirect to 0x0000_0103 while in S_WAIT -> next rvalid discarded, next imem_addr=0x0000_0100, if_valid=0 until that response.
REQ-040 redirect and rvalid same cycle with stall=1 -> if_valid=0 next cycle, data dropped, imem_addr=redirect target.
REQ-041 redirect to 0xFFFF_FFFC -> following fetch address 0x0000_0000.
REQ-042 rst asserted in S_WAIT, rvalid arrives the cycle after -> ignored; first fetch at RESET_PC; with IF_PERF_CNT_EN, counters read 0.
